instr_encoder: RTL and testbench

Instruction encoder and streamer: accepts one operation descriptor per handshake (operation select plus register, shift and immediate fields), packs it into the 32-bit MIPS32 word that the controller decodes, and queues it with a sequential instruction-memory address. Sits between the test/program-load front end and the instruction memory write port. It is the encode side of the controller's decode table. Only operations the controller decodes are encodable.

---
 rtl/instr_encoder.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs operation descriptors into MIPS32 instruction words and queues them,
// each tagged with a sequential instruction-memory word address.
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [5:0]               i_op,
    input  logic [4:0]               i_rs,
    input  logic [4:0]               i_rt,
    input  logic [4:0]               i_rd,
    input  logic [4:0]               i_shamt,
    input  logic [15:0]              i_imm,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [31:0]              o_out_instr,
    output logic [ADDR_W-1:0]        o_out_addr,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_bad_op
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_ADDU  = 6'd2;
    localparam logic [5:0] OP_SUB   = 6'd3;
    localparam logic [5:0] OP_MULT  = 6'd4;
    localparam logic [5:0] OP_MULTU = 6'd5;
    localparam logic [5:0] OP_AND   = 6'd6;
    localparam logic [5:0] OP_OR    = 6'd7;
    localparam logic [5:0] OP_XOR   = 6'd8;
    localparam logic [5:0] OP_NOR   = 6'd9;
    localparam logic [5:0] OP_SLL   = 6'd10;
    localparam logic [5:0] OP_SLLV  = 6'd11;
    localparam logic [5:0] OP_SRL   = 6'd12;
    localparam logic [5:0] OP_ROTR  = 6'd13;
    localparam logic [5:0] OP_SRLV  = 6'd14;
    localparam logic [5:0] OP_ROTRV = 6'd15;
    localparam logic [5:0] OP_SRA   = 6'd16;
    localparam logic [5:0] OP_SRAV  = 6'd17;
    localparam logic [5:0] OP_SLT   = 6'd18;
    localparam logic [5:0] OP_SLTU  = 6'd19;
    localparam logic [5:0] OP_MOVZ  = 6'd20;
    localparam logic [5:0] OP_MOVN  = 6'd21;
    localparam logic [5:0] OP_MFHI  = 6'd22;
    localparam logic [5:0] OP_MTHI  = 6'd23;
    localparam logic [5:0] OP_MFLO  = 6'd24;
    localparam logic [5:0] OP_MTLO  = 6'd25;
    localparam logic [5:0] OP_ADDI  = 6'd26;
    localparam logic [5:0] OP_ADDIU = 6'd27;
    localparam logic [5:0] OP_SLTI  = 6'd28;
    localparam logic [5:0] OP_SLTIU = 6'd29;
    localparam logic [5:0] OP_ANDI  = 6'd30;
    localparam logic [5:0] OP_ORI   = 6'd31;
    localparam logic [5:0] OP_XORI  = 6'd32;
    localparam logic [5:0] OP_MADD  = 6'd33;
    localparam logic [5:0] OP_MUL   = 6'd34;
    localparam logic [5:0] OP_MSUB  = 6'd35;
    localparam logic [5:0] OP_SEB   = 6'd36;
    localparam logic [5:0] OP_SEH   = 6'd37;

    localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
    localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OPC_SPECIAL3 = 6'b011111;

    logic [5:0]         w_opcode;
    logic [4:0]         w_rs;
    logic [4:0]         w_rt;
    logic [4:0]         w_rd;
    logic [4:0]         w_sa;
    logic [5:0]         w_funct;
    logic               w_itype;
    logic               w_opValid;
    logic [31:0]        w_instr;

    logic [31:0]        r_instrMem [DEPTH];
    logic [ADDR_W-1:0]  r_addrMem  [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_badOp;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;

    // Field selection: start from the raw descriptor and force the fields each op ignores.
    always_comb begin
        w_opcode  = OPC_SPECIAL;
        w_rs      = i_rs;
        w_rt      = i_rt;
        w_rd      = i_rd;
        w_sa      = 5'd0;
        w_funct   = 6'b000000;
        w_itype   = 1'b0;
        w_opValid = 1'b1;
        case (i_op)
            OP_NOP: begin
                w_rs = 5'd0;
                w_rt = 5'd0;
                w_rd = 5'd0;
            end
            OP_ADD:   w_funct = 6'b100000;
            OP_ADDU:  w_funct = 6'b100001;
            OP_SUB:   w_funct = 6'b100010;
            OP_MULT: begin
                w_funct = 6'b011000;
                w_rd    = 5'd0;
            end
            OP_MULTU: begin
                w_funct = 6'b011001;
                w_rd    = 5'd0;
            end
            OP_AND:   w_funct = 6'b100100;
            OP_OR:    w_funct = 6'b100101;
            OP_XOR:   w_funct = 6'b100110;
            OP_NOR:   w_funct = 6'b100111;
            OP_SLL: begin
                w_funct = 6'b000000;
                w_rs    = 5'd0;
                w_sa    = i_shamt;
            end
            OP_SLLV:  w_funct = 6'b000100;
            OP_SRL: begin
                w_funct = 6'b000010;
                w_rs    = 5'd0;
                w_sa    = i_shamt;
            end
            // rotr/rotrv share srl/srlv functs; the R bit in rs or sa selects rotate.
            OP_ROTR: begin
                w_funct = 6'b000010;
                w_rs    = 5'd1;
                w_sa    = i_shamt;
            end
            OP_SRLV:  w_funct = 6'b000110;
            OP_ROTRV: begin
                w_funct = 6'b000110;
                w_sa    = 5'd1;
            end
            OP_SRA: begin
                w_funct = 6'b000011;
                w_rs    = 5'd0;
                w_sa    = i_shamt;
            end
            OP_SRAV:  w_funct = 6'b000111;
            OP_SLT:   w_funct = 6'b101010;
            OP_SLTU:  w_funct = 6'b101011;
            OP_MOVZ:  w_funct = 6'b001010;
            OP_MOVN:  w_funct = 6'b001011;
            OP_MFHI: begin
                w_funct = 6'b010000;
                w_rs    = 5'd0;
                w_rt    = 5'd0;
            end
            OP_MTHI: begin
                w_funct = 6'b010001;
                w_rt    = 5'd0;
                w_rd    = 5'd0;
            end
            OP_MFLO: begin
                w_funct = 6'b010010;
                w_rs    = 5'd0;
                w_rt    = 5'd0;
            end
            OP_MTLO: begin
                w_funct = 6'b010011;
                w_rt    = 5'd0;
                w_rd    = 5'd0;
            end
            OP_ADDI: begin
                w_opcode = 6'b001000;
                w_itype  = 1'b1;
            end
            OP_ADDIU: begin
                w_opcode = 6'b001001;
                w_itype  = 1'b1;
            end
            OP_SLTI: begin
                w_opcode = 6'b001010;
                w_itype  = 1'b1;
            end
            OP_SLTIU: begin
                w_opcode = 6'b001011;
                w_itype  = 1'b1;
            end
            OP_ANDI: begin
                w_opcode = 6'b001100;
                w_itype  = 1'b1;
            end
            OP_ORI: begin
                w_opcode = 6'b001101;
                w_itype  = 1'b1;
            end
            OP_XORI: begin
                w_opcode = 6'b001110;
                w_itype  = 1'b1;
            end
            OP_MADD: begin
                w_opcode = OPC_SPECIAL2;
                w_funct  = 6'b000000;
                w_rd     = 5'd0;
            end
            OP_MUL: begin
                w_opcode = OPC_SPECIAL2;
                w_funct  = 6'b000010;
            end
            OP_MSUB: begin
                w_opcode = OPC_SPECIAL2;
                w_funct  = 6'b000100;
                w_rd     = 5'd0;
            end
            OP_SEB: begin
                w_opcode = OPC_SPECIAL3;
                w_rs     = 5'd0;
                w_sa     = 5'b10000;
                w_funct  = 6'b100000;
            end
            OP_SEH: begin
                w_opcode = OPC_SPECIAL3;
                w_rs     = 5'd0;
                w_sa     = 5'b11000;
                w_funct  = 6'b100000;
            end
            default: begin
                w_opValid = 1'b0;
                w_rs      = 5'd0;
                w_rt      = 5'd0;
                w_rd      = 5'd0;
            end
        endcase
    end

    assign w_instr = w_itype ? {w_opcode, w_rs, w_rt, i_imm}
                             : {w_opcode, w_rs, w_rt, w_rd, w_sa, w_funct};

    assign o_in_ready  = (r_count < CNT_W'(DEPTH));
    assign o_out_valid = (r_count != '0);
    assign o_count     = r_count;
    assign o_bad_op    = r_badOp;
    assign o_out_instr = o_out_valid ? r_instrMem[r_rdPtr] : 32'd0;
    assign o_out_addr  = o_out_valid ? r_addrMem[r_rdPtr]  : '0;

    // Flush wins over everything, so an unencodable op offered with flush raises no bad_op.
    assign w_accept = i_in_valid & o_in_ready;
    assign w_push   = w_accept & w_opValid & ~i_flush;
    assign w_pop    = o_out_valid & i_out_ready & ~i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_addr  <= '0;
            r_badOp <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instrMem[i] <= 32'd0;
                r_addrMem[i]  <= '0;
            end
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_addr  <= '0;
            r_badOp <= 1'b0;
        end else begin
            r_badOp <= w_accept & ~w_opValid;
            if (w_push) begin
                r_instrMem[r_wrPtr] <= w_instr;
                r_addrMem[r_wrPtr]  <= r_addr;
                r_wrPtr             <= r_wrPtr + 1'b1;
                r_addr              <= r_addr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a default instance (ADDR_W=8) plus a
// narrow-address instance (ADDR_W=2) for wrap and mid-stream reset.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n, flush, inValid, outReady;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic        inReady, outValid, badOp;
    logic [31:0] outInstr;
    logic [7:0]  outAddr;
    logic [2:0]  count;

    logic        bRst_n, bFlush, bInValid, bOutReady;
    logic        bInReady, bOutValid, bBadOp;
    logic [31:0] bOutInstr;
    logic [1:0]  bOutAddr;
    logic [2:0]  bCount;

    logic [39:0] expQ[$];
    logic [7:0]  modelAddr;
    logic        expBad;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(inValid),
        .o_in_ready(inReady), .i_op(op), .i_rs(rs), .i_rt(rt), .i_rd(rd),
        .i_shamt(sh), .i_imm(imm), .o_out_valid(outValid), .i_out_ready(outReady),
        .o_out_instr(outInstr), .o_out_addr(outAddr), .o_count(count), .o_bad_op(badOp)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2)) dutNarrow (
        .i_clk(clk), .i_rst_n(bRst_n), .i_flush(bFlush), .i_in_valid(bInValid),
        .o_in_ready(bInReady), .i_op(op), .i_rs(rs), .i_rt(rt), .i_rd(rd),
        .i_shamt(sh), .i_imm(imm), .o_out_valid(bOutValid), .i_out_ready(bOutReady),
        .o_out_instr(bOutInstr), .o_out_addr(bOutAddr), .o_count(bCount), .o_bad_op(bBadOp)
    );

    // Reference encoding written directly from the op table.
    function automatic logic [31:0] encModel(input int o, input logic [4:0] s, input logic [4:0] t,
                                             input logic [4:0] d, input logic [4:0] a,
                                             input logic [15:0] im);
        logic [5:0] fn;
        logic [4:0] xs, xt, xd, xa;
        xs = s; xt = t; xd = d; xa = 5'd0; fn = 6'd0;
        case (o)
            0:  return 32'd0;
            1:  fn = 6'h20;
            2:  fn = 6'h21;
            3:  fn = 6'h22;
            4:  begin fn = 6'h18; xd = 5'd0; end
            5:  begin fn = 6'h19; xd = 5'd0; end
            6:  fn = 6'h24;
            7:  fn = 6'h25;
            8:  fn = 6'h26;
            9:  fn = 6'h27;
            10: begin fn = 6'h00; xs = 5'd0; xa = a; end
            11: fn = 6'h04;
            12: begin fn = 6'h02; xs = 5'd0; xa = a; end
            13: begin fn = 6'h02; xs = 5'd1; xa = a; end
            14: fn = 6'h06;
            15: begin fn = 6'h06; xa = 5'd1; end
            16: begin fn = 6'h03; xs = 5'd0; xa = a; end
            17: fn = 6'h07;
            18: fn = 6'h2a;
            19: fn = 6'h2b;
            20: fn = 6'h0a;
            21: fn = 6'h0b;
            22: begin fn = 6'h10; xs = 5'd0; xt = 5'd0; end
            23: begin fn = 6'h11; xt = 5'd0; xd = 5'd0; end
            24: begin fn = 6'h12; xs = 5'd0; xt = 5'd0; end
            25: begin fn = 6'h13; xt = 5'd0; xd = 5'd0; end
            26, 27, 28, 29, 30, 31, 32: return {6'(8 + o - 26), s, t, im};
            33: return {6'h1c, s, t, 5'd0, 5'd0, 6'h00};
            34: return {6'h1c, s, t, d, 5'd0, 6'h02};
            35: return {6'h1c, s, t, 5'd0, 5'd0, 6'h04};
            36: return {6'h1f, 5'd0, t, d, 5'h10, 6'h20};
            37: return {6'h1f, 5'd0, t, d, 5'h18, 6'h20};
            default: return 32'd0;
        endcase
        return {6'd0, xs, xt, xd, xa, fn};
    endfunction

    task automatic setDesc(input int o, input logic [4:0] s, input logic [4:0] t,
                           input logic [4:0] d, input logic [4:0] a, input logic [15:0] im);
        op = 6'(o); rs = s; rt = t; rd = d; sh = a; imm = im;
    endtask

    // Advances the scoreboard for the default instance by one clock, then waits for the edge.
    task automatic tick();
        bit acc, pop, opOk;
        opOk = (op <= 6'd37);
        acc  = inValid && (expQ.size() < 4);
        pop  = outReady && (expQ.size() > 0);
        expBad = 1'b0;
        if (flush) begin
            expQ.delete();
            modelAddr = 8'd0;
        end else begin
            if (pop) expQ.delete(0);
            if (acc && opOk) begin
                expQ.push_back({modelAddr, encModel(int'(op), rs, rt, rd, sh, imm)});
                modelAddr = modelAddr + 8'd1;
            end
            expBad = acc && !opOk;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bRst_n = 1'b0; flush = 1'b0; bFlush = 1'b0;
        inValid = 1'b0; outReady = 1'b0; bInValid = 1'b0; bOutReady = 1'b0;
        setDesc(0, 0, 0, 0, 0, 0);
        modelAddr = 8'd0; expBad = 1'b0;
        #12;
        compared++; if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready got %b want 1", inReady); end
        compared++; if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid got %b want 0", outValid); end
        compared++; if (outInstr !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_out_instr got %h want 0", outInstr); end
        compared++; if (outAddr !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_out_addr got %h want 0", outAddr); end
        compared++; if (count !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_count got %0d want 0", count); end
        compared++; if (badOp !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_bad_op got %b want 0", badOp); end
        @(negedge clk);
        rst_n = 1'b1; bRst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        setDesc(1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0);
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        compared++; if (outValid !== 1'b1) begin mismatched++; $display("[TB] FAIL add_valid got %b want 1", outValid); end
        compared++; if (outInstr !== 32'h00221820) begin mismatched++; $display("[TB] FAIL add_instr got %h want 00221820", outInstr); end
        compared++; if (outAddr !== 8'd0) begin mismatched++; $display("[TB] FAIL add_addr got %0d want 0", outAddr); end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        compared++; if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL add_drain_valid got %b want 0", outValid); end
        compared++; if (outInstr !== 32'd0) begin mismatched++; $display("[TB] FAIL add_drain_instr got %h want 0", outInstr); end
    endtask

    task automatic test_field_forcing();
        logic [31:0] wantI[4];
        logic [7:0]  wantA[4];
        wantI[0] = 32'h2005FFFF; wantI[1] = 32'h002220C2;
        wantI[2] = 32'h7C063C20; wantI[3] = 32'h00004010;
        for (int i = 0; i < 4; i++) wantA[i] = 8'(i + 1);
        inValid = 1'b1;
        setDesc(26, 5'd0, 5'd5, 5'd0, 5'd0, 16'hFFFF); tick();
        setDesc(13, 5'd9, 5'd2, 5'd4, 5'd3, 16'd0);    tick();
        setDesc(36, 5'd0, 5'd6, 5'd7, 5'd0, 16'd0);    tick();
        setDesc(22, 5'd31, 5'd31, 5'd8, 5'd0, 16'd0);  tick();
        inValid = 1'b0;
        compared++; if (count !== 3'd4) begin mismatched++; $display("[TB] FAIL fields_count got %0d want 4", count); end
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            compared++; if (outInstr !== wantI[i]) begin mismatched++; $display("[TB] FAIL fields_instr[%0d] got %h want %h", i, outInstr, wantI[i]); end
            compared++; if (outAddr !== wantA[i]) begin mismatched++; $display("[TB] FAIL fields_addr[%0d] got %0d want %0d", i, outAddr, wantA[i]); end
            tick();
        end
        outReady = 1'b0;
        compared++; if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL fields_empty got %b want 0", outValid); end
    endtask

    task automatic test_all_ops();
        outReady = 1'b1;
        inValid  = 1'b1;
        for (int o = 0; o <= 37; o++) begin
            setDesc(o, 5'h11, 5'h0A, 5'h15, 5'h07, 16'hA5C3);
            tick();
            compared++; if (outValid !== 1'b1 || expQ.size() != 1) begin mismatched++; $display("[TB] FAIL ops_valid[%0d] got %b want 1", o, outValid); end
            else begin
                compared++; if (outInstr !== expQ[0][31:0]) begin mismatched++; $display("[TB] FAIL ops_instr[%0d] got %h want %h", o, outInstr, expQ[0][31:0]); end
                compared++; if (outAddr !== expQ[0][39:32]) begin mismatched++; $display("[TB] FAIL ops_addr[%0d] got %0d want %0d", o, outAddr, expQ[0][39:32]); end
            end
        end
        inValid = 1'b0;
        tick();
        outReady = 1'b0;
        compared++; if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL ops_drain got %b want 0", outValid); end
    endtask

    task automatic test_full();
        outReady = 1'b0;
        inValid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            setDesc(7, 5'd1, 5'd2, 5'(i), 5'd0, 16'd0);
            compared++; if (inReady !== (i < 4)) begin mismatched++; $display("[TB] FAIL full_ready[%0d] got %b want %b", i, inReady, (i < 4)); end
            tick();
        end
        compared++; if (count !== 3'd4) begin mismatched++; $display("[TB] FAIL full_count got %0d want 4", count); end
        outReady = 1'b1;
        compared++; if (inReady !== 1'b0) begin mismatched++; $display("[TB] FAIL full_ready_with_pop got %b want 0", inReady); end
        tick();
        outReady = 1'b0;
        compared++; if (count !== 3'd3) begin mismatched++; $display("[TB] FAIL full_after_pop got %0d want 3", count); end
        tick();
        inValid = 1'b0;
        compared++; if (count !== 3'd4) begin mismatched++; $display("[TB] FAIL full_fifth_in got %0d want 4", count); end
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            compared++; if (outInstr !== expQ[0][31:0] || outAddr !== expQ[0][39:32]) begin
                mismatched++; $display("[TB] FAIL full_order[%0d] got %h@%0d want %h@%0d", i, outInstr, outAddr, expQ[0][31:0], expQ[0][39:32]);
            end
            tick();
        end
        outReady = 1'b0;
    endtask

    task automatic test_bad_op();
        logic [7:0] addrBefore;
        addrBefore = modelAddr;
        setDesc(45, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0);
        inValid = 1'b1;
        compared++; if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL bad_ready got %b want 1", inReady); end
        tick();
        inValid = 1'b0;
        compared++; if (badOp !== 1'b1) begin mismatched++; $display("[TB] FAIL bad_pulse got %b want 1", badOp); end
        compared++; if (count !== 3'd0) begin mismatched++; $display("[TB] FAIL bad_count got %0d want 0", count); end
        tick();
        compared++; if (badOp !== 1'b0) begin mismatched++; $display("[TB] FAIL bad_one_cycle got %b want 0", badOp); end
        setDesc(2, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0);
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        compared++; if (outAddr !== addrBefore) begin mismatched++; $display("[TB] FAIL bad_next_addr got %0d want %0d", outAddr, addrBefore); end
        compared++; if (outInstr !== 32'h00853021) begin mismatched++; $display("[TB] FAIL bad_next_instr got %h want 00853021", outInstr); end
    endtask

    task automatic test_flush();
        inValid = 1'b1;
        setDesc(1, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0);
        tick();
        flush = 1'b1;
        setDesc(45, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0);
        outReady = 1'b1;
        tick();
        flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        compared++; if (count !== 3'd0) begin mismatched++; $display("[TB] FAIL flush_count got %0d want 0", count); end
        compared++; if (badOp !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_bad got %b want 0", badOp); end
        setDesc(6, 5'd3, 5'd4, 5'd5, 5'd0, 16'd0);
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        compared++; if (outAddr !== 8'd0 || outValid !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_addr got %0d/%b want 0/1", outAddr, outValid); end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
    endtask

    task automatic test_addr_wrap();
        logic [1:0] wantAddr;
        bOutReady = 1'b1;
        bInValid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            setDesc(3, 5'd2, 5'd3, 5'(i + 8), 5'd0, 16'd0);
            @(posedge clk);
            #1;
            wantAddr = 2'(i);
            compared++; if (bOutAddr !== wantAddr || bCount !== 3'd1) begin mismatched++; $display("[TB] FAIL wrap_addr[%0d] got %0d cnt %0d want %0d cnt 1", i, bOutAddr, bCount, wantAddr); end
            compared++; if (bOutInstr !== encModel(3, 5'd2, 5'd3, 5'(i + 8), 5'd0, 16'd0)) begin mismatched++; $display("[TB] FAIL wrap_instr[%0d] got %h", i, bOutInstr); end
        end
        bInValid = 1'b0;
        @(posedge clk);
        #1;
        bOutReady = 1'b0;
    endtask

    task automatic test_async_reset();
        bInValid = 1'b1;
        setDesc(7, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0);
        repeat (3) begin @(posedge clk); #1; end
        bInValid = 1'b0;
        compared++; if (bCount !== 3'd3) begin mismatched++; $display("[TB] FAIL rst_pre_count got %0d want 3", bCount); end
        #2;
        bRst_n = 1'b0;
        #1;
        compared++; if (bOutValid !== 1'b0 || bCount !== 3'd0) begin mismatched++; $display("[TB] FAIL rst_async got valid %b cnt %0d want 0/0", bOutValid, bCount); end
        @(negedge clk);
        bRst_n = 1'b1;
        @(posedge clk);
        #1;
        bInValid = 1'b1;
        @(posedge clk);
        #1;
        bInValid = 1'b0;
        compared++; if (bOutValid !== 1'b1 || bOutAddr !== 2'd0) begin mismatched++; $display("[TB] FAIL rst_restart got valid %b addr %0d want 1/0", bOutValid, bOutAddr); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_field_forcing();
        test_all_ops();
        test_full();
        test_bad_op();
        test_flush();
        test_addr_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
